// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel PWM generator sharing one edge- or center-aligned period counter.
// Duty, period and mode are double-buffered and switch over only at a period boundary.
module pwm_multi_ch #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PERIOD_RST = 255,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    input  logic [WIDTH-1:0]    period_max,
    input  logic                center_mode,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]    cnt_reg;
    logic [WIDTH-1:0]    cnt_next;
    logic                dir_down_reg;
    logic                dir_down_next;
    logic [WIDTH-1:0]    active_p_reg;
    logic                active_center_reg;
    logic [WIDTH-1:0]    shadow_duty_reg [CHANNELS];
    logic [WIDTH-1:0]    active_duty_reg [CHANNELS];
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] pwm_next;
    logic [CHANNELS-1:0] pwm_out_reg;
    logic                period_start_reg;
    logic                boundary;
    logic                load_active;

    // Counter sequencing. boundary marks the edge that reloads cnt with 0 from its terminal value.
    always_comb begin
        cnt_next      = cnt_reg;
        dir_down_next = dir_down_reg;
        boundary      = 1'b0;
        if (!active_center_reg) begin
            if (cnt_reg == active_p_reg) begin
                boundary = 1'b1;
            end else begin
                cnt_next = cnt_reg + ONE;
            end
        end else if (!dir_down_reg) begin
            if (cnt_reg == active_p_reg) begin
                // P of 0 or 1 has no down-count: the peak is already the terminal value.
                if (active_p_reg <= ONE) begin
                    boundary = 1'b1;
                end else begin
                    cnt_next      = cnt_reg - ONE;
                    dir_down_next = 1'b1;
                end
            end else begin
                cnt_next = cnt_reg + ONE;
            end
        end else begin
            if (cnt_reg <= ONE) begin
                boundary = 1'b1;
            end else begin
                cnt_next = cnt_reg - ONE;
            end
        end
        if (boundary) begin
            cnt_next      = '0;
            dir_down_next = 1'b0;
        end
    end

    // While stopped, the active set tracks the shadows so a restart uses current settings.
    assign load_active = !en || boundary;

    // Per-channel write decode and duty compare; indices at or above CHANNELS never match.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign wr_hit[gi]   = wr_en && (wr_ch == CH_W'(gi));
            assign pwm_next[gi] = cnt_reg < active_duty_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg           <= '0;
            dir_down_reg      <= 1'b0;
            active_p_reg      <= WIDTH'(PERIOD_RST);
            active_center_reg <= 1'b0;
            pwm_out_reg       <= '0;
            period_start_reg  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_duty_reg[i] <= '0;
                active_duty_reg[i] <= '0;
            end
        end else begin
            // Active copies read the pre-edge shadow, so a write on the boundary waits a period.
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_hit[i]) begin
                    shadow_duty_reg[i] <= wr_duty;
                end
                if (load_active) begin
                    active_duty_reg[i] <= shadow_duty_reg[i];
                end
            end
            if (load_active) begin
                active_p_reg      <= period_max;
                active_center_reg <= center_mode;
            end
            if (en) begin
                cnt_reg          <= cnt_next;
                dir_down_reg     <= dir_down_next;
                pwm_out_reg      <= pwm_next;
                period_start_reg <= (cnt_reg == '0) && !dir_down_reg;
            end else begin
                cnt_reg          <= '0;
                dir_down_reg     <= 1'b0;
                pwm_out_reg      <= '0;
                period_start_reg <= 1'b0;
            end
        end
    end

    assign pwm_out      = pwm_out_reg;
    assign period_start = period_start_reg;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: directed checks of pwm_multi_ch waveforms, buffering, reset and enable behaviour.
// Five channels are used so that wr_ch values 5..7 are representable yet out of range.
module tb_pwm_multi_ch;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 5;
    localparam int CH_W     = 3;

    typedef logic [CHANNELS-1:0][WIDTH-1:0] duty_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic [WIDTH-1:0]    wr_duty;
    logic [WIDTH-1:0]    period_max;
    logic                center_mode;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_start;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_multi_ch #(
        .WIDTH(WIDTH),
        .CHANNELS(CHANNELS),
        .PERIOD_RST(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .wr_en(wr_en),
        .wr_ch(wr_ch),
        .wr_duty(wr_duty),
        .period_max(period_max),
        .center_mode(center_mode),
        .pwm_out(pwm_out),
        .period_start(period_start)
    );

    // Outputs are sampled and inputs changed 1 ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_duty(input int ch, input int d);
        wr_en   = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_duty = WIDTH'(d);
        step();
        wr_en   = 1'b0;
    endtask

    // Expected outputs for the cycle that shows counter phase ph of a period.
    function automatic logic [CHANNELS-1:0] exp_vec(input int ph, input int p, input bit center,
                                                     input duty_t d);
        int c;
        c = (center && ph > p) ? 2 * p - ph : ph;
        for (int i = 0; i < CHANNELS; i++) begin
            exp_vec[i] = (c < int'(d[i]));
        end
    endfunction

    task automatic configure(input int p, input bit center, input duty_t d);
        en          = 1'b0;
        period_max  = WIDTH'(p);
        center_mode = center;
        for (int i = 0; i < CHANNELS; i++) begin
            write_duty(i, int'(d[i]));
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        step();
        step();
        n_vec++;
        if (pwm_out !== '0 || period_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: pwm_out=%b period_start=%b, required 00000 0", pwm_out, period_start);
        end
        rst = 1'b0;
        step();
        n_vec++;
        if (pwm_out !== '0 || period_start !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: pwm_out=%b period_start=%b, required 00000 1", pwm_out, period_start);
        end
        step();
        n_vec++;
        if (pwm_out !== '0 || period_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_second: pwm_out=%b period_start=%b, required 00000 0", pwm_out, period_start);
        end
    endtask

    task automatic test_edge();
        duty_t d;
        int    hi0;
        d    = '0;
        d[0] = 8'd3;
        d[1] = 8'd0;
        d[2] = 8'd10;
        d[3] = 8'd9;
        configure(9, 1'b0, d);
        en = 1'b1;
        step();
        hi0 = 0;
        for (int k = 0; k < 500; k++) begin
            int                  ph;
            logic [CHANNELS-1:0] ev;
            ph = k % 10;
            ev = exp_vec(ph, 9, 1'b0, d);
            n_vec++;
            if (pwm_out !== ev || period_start !== (ph == 0)) begin
                n_err++;
                $display("FAIL edge k=%0d: pwm_out=%b period_start=%b, required %b %b",
                         k, pwm_out, period_start, ev, ph == 0);
            end
            hi0 += int'(pwm_out[0] === 1'b1);
            if (ph == 9) begin
                n_vec++;
                if (hi0 != 3) begin
                    n_err++;
                    $display("FAIL edge_high_count k=%0d: ch0 high %0d cycles, required 3", k, hi0);
                end
                hi0 = 0;
            end
            step();
        end
    endtask

    task automatic test_center();
        duty_t d;
        int    hi0;
        int    hi1;
        d    = '0;
        d[0] = 8'd2;
        d[1] = 8'd4;
        d[2] = 8'd5;
        d[3] = 8'd1;
        configure(4, 1'b1, d);
        en = 1'b1;
        step();
        hi0 = 0;
        hi1 = 0;
        for (int k = 0; k < 32; k++) begin
            int                  ph;
            logic [CHANNELS-1:0] ev;
            ph = k % 8;
            ev = exp_vec(ph, 4, 1'b1, d);
            n_vec++;
            if (pwm_out !== ev || period_start !== (ph == 0)) begin
                n_err++;
                $display("FAIL center k=%0d: pwm_out=%b period_start=%b, required %b %b",
                         k, pwm_out, period_start, ev, ph == 0);
            end
            hi0 += int'(pwm_out[0] === 1'b1);
            hi1 += int'(pwm_out[1] === 1'b1);
            if (ph == 7) begin
                n_vec++;
                if (hi0 != 3 || hi1 != 7) begin
                    n_err++;
                    $display("FAIL center_high_count k=%0d: ch0=%0d ch1=%0d, required 3 7", k, hi0, hi1);
                end
                hi0 = 0;
                hi1 = 0;
            end
            step();
        end
    endtask

    task automatic test_center_p0();
        duty_t d;
        d    = '0;
        d[0] = 8'd1;
        configure(0, 1'b1, d);
        en = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (pwm_out !== 5'b00001 || period_start !== 1'b1) begin
                n_err++;
                $display("FAIL center_p0 k=%0d: pwm_out=%b period_start=%b, required 00001 1",
                         k, pwm_out, period_start);
            end
            step();
        end
    endtask

    // Write during phase 4 -> 5 edge: new duty shows from the next period.
    task automatic test_mid_write();
        duty_t d;
        d    = '0;
        d[0] = 8'd3;
        configure(9, 1'b0, d);
        en = 1'b1;
        step();
        for (int k = 0; k < 30; k++) begin
            int   ph;
            logic e0;
            ph = k % 10;
            e0 = (ph < ((k < 10) ? 3 : 7));
            n_vec++;
            if (pwm_out[0] !== e0 || period_start !== (ph == 0)) begin
                n_err++;
                $display("FAIL mid_write k=%0d: ch0=%b period_start=%b, required %b %b",
                         k, pwm_out[0], period_start, e0, ph == 0);
            end
            wr_en   = (k == 4);
            wr_ch   = 3'd0;
            wr_duty = 8'd7;
            step();
        end
        wr_en = 1'b0;
    endtask

    // Write held across the boundary edge (phase 8 -> 9): old shadow loads, new one a period later.
    task automatic test_back_to_back();
        duty_t d;
        d    = '0;
        d[0] = 8'd3;
        configure(9, 1'b0, d);
        en = 1'b1;
        step();
        for (int k = 0; k < 30; k++) begin
            int   ph;
            logic e0;
            ph = k % 10;
            e0 = (ph < ((k < 20) ? 3 : 7));
            n_vec++;
            if (pwm_out[0] !== e0 || period_start !== (ph == 0)) begin
                n_err++;
                $display("FAIL boundary_write k=%0d: ch0=%b period_start=%b, required %b %b",
                         k, pwm_out[0], period_start, e0, ph == 0);
            end
            wr_en   = (k == 8);
            wr_ch   = 3'd0;
            wr_duty = 8'd7;
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        duty_t d;
        d    = '0;
        d[0] = 8'd3;
        d[2] = 8'd10;
        configure(9, 1'b0, d);
        en = 1'b1;
        step();
        step();
        n_vec++;
        if (pwm_out !== 5'b00101) begin
            n_err++;
            $display("FAIL reset_mid_pre: pwm_out=%b, required 00101", pwm_out);
        end
        rst = 1'b1;
        step();
        n_vec++;
        if (pwm_out !== '0 || period_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: pwm_out=%b period_start=%b, required 00000 0", pwm_out, period_start);
        end
        rst = 1'b0;
        step();
        n_vec++;
        if (pwm_out !== '0 || period_start !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_restart: pwm_out=%b period_start=%b, required 00000 1",
                     pwm_out, period_start);
        end
        // Duties were cleared and P is back to 255: nothing toggles for a while.
        for (int k = 1; k < 21; k++) begin
            step();
            n_vec++;
            if (pwm_out !== '0 || period_start !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_after k=%0d: pwm_out=%b period_start=%b, required 00000 0",
                         k, pwm_out, period_start);
            end
        end
    endtask

    task automatic test_bad_ch();
        duty_t d;
        d    = '0;
        d[0] = 8'd3;
        d[2] = 8'd10;
        d[3] = 8'd9;
        d[4] = 8'd5;
        configure(9, 1'b0, d);
        write_duty(5, 8);
        write_duty(6, 8);
        write_duty(7, 8);
        step();
        step();
        en = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            logic [CHANNELS-1:0] ev;
            ev = exp_vec(k, 9, 1'b0, d);
            n_vec++;
            if (pwm_out !== ev || period_start !== (k == 0)) begin
                n_err++;
                $display("FAIL bad_ch k=%0d: pwm_out=%b period_start=%b, required %b %b",
                         k, pwm_out, period_start, ev, k == 0);
            end
            step();
        end
    endtask

    task automatic test_en_drop();
        duty_t d;
        d    = '0;
        d[0] = 8'd3;
        d[2] = 8'd10;
        configure(9, 1'b0, d);
        en = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            step();
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if (pwm_out !== '0 || period_start !== 1'b0) begin
                n_err++;
                $display("FAIL en_low k=%0d: pwm_out=%b period_start=%b, required 00000 0",
                         k, pwm_out, period_start);
            end
        end
        en = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            logic [CHANNELS-1:0] ev;
            ev = exp_vec(k, 9, 1'b0, d);
            n_vec++;
            if (pwm_out !== ev || period_start !== (k == 0)) begin
                n_err++;
                $display("FAIL en_restart k=%0d: pwm_out=%b period_start=%b, required %b %b",
                         k, pwm_out, period_start, ev, k == 0);
            end
            step();
        end
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        wr_en       = 1'b0;
        wr_ch       = '0;
        wr_duty     = '0;
        period_max  = 8'd9;
        center_mode = 1'b0;
        test_reset();
        test_edge();
        test_center();
        test_center_p0();
        test_mid_write();
        test_back_to_back();
        test_reset_mid();
        test_bad_ch();
        test_en_drop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at 500000 ns, required completion earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
